// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one external combinational 8-bit ALU among NREQ requesters.
//   A round-robin arbiter accepts one operation at a time. The operands are
//   registered and presented to the ALU for one cycle. The result is captured
//   and returned, tagged with the requester ID, on a valid/ready response port.
//   A divide with b == 0 is trapped: the ALU is not enabled, and the response
//   carries err = 1 with zero data.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_cmd   packed per-requester operands and command
//   alu_a/alu_b/alu_cmd   registered operands to the ALU (hold outside EXEC)
//   alu_oe                ALU output enable, high only in EXEC when not trapped
//   alu_out               ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_data/rsp_err  response payload, stable while rsp_valid
//   busy                  high while a transaction is in flight
module alu_rr_scheduler #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2,
  parameter logic [3:0]  DIV_OP = 4'b0101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_cmd,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_cmd,
  output logic              alu_oe,
  input  logic [15:0]       alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     data_q, data_d;
  logic            err_q, err_d;

  logic            found;
  int unsigned     win_idx;
  logic            trap;

  // Round-robin search starting at rr_q; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(32'(rr_q) + k) % NREQ]) begin
        found   = 1'b1;
        win_idx = (32'(rr_q) + k) % NREQ;
      end
    end
  end

  assign trap = (cmd_q == DIV_OP) && (b_q == '0);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    a_d       = a_q;
    b_d       = b_q;
    cmd_d     = cmd_q;
    id_d      = id_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    alu_oe    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The grant is suppressed during reset, so an accept is never
        // signalled for an operation that would be dropped.
        if (found && !rst) begin
          req_ready[win_idx] = 1'b1;
          a_d     = req_a[win_idx*8 +: 8];
          b_d     = req_b[win_idx*8 +: 8];
          cmd_d   = req_cmd[win_idx*4 +: 4];
          id_d    = IDW'(win_idx);
          rr_d    = IDW'((win_idx + 1) % NREQ);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_oe  = !trap;
        data_d  = trap ? '0 : alu_out;
        err_d   = trap;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cmd   = cmd_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam logic [3:0]  DIV  = 4'b0101;
  localparam logic [3:0]  ADD  = 4'd0;
  localparam logic [3:0]  MUL  = 4'd6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [4*NREQ-1:0] req_cmd;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [3:0]        alu_cmd;
  logic              alu_oe;
  logic [15:0]       alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .DIV_OP(DIV)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Environment ALU; an un-trapped divide by zero yields a marker value.
  function automatic logic [15:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [3:0] c);
    case (c)
      4'd0:  return 16'(a) + 16'(b);
      4'd1:  return 16'(a) - 16'(b);
      4'd2:  return 16'(a & b);
      4'd3:  return 16'(a | b);
      4'd4:  return 16'(a ^ b);
      4'd5:  return (b == 0) ? 16'hDEAD : 16'(a / b);
      4'd6:  return 16'(a) * 16'(b);
      4'd7:  return {b, a};
      4'd8:  return 16'(a) << b[2:0];
      4'd9:  return 16'(a >> b[2:0]);
      4'd10: return 16'(~a);
      4'd11: return 16'(a) + 16'd1;
      4'd12: return 16'(a) - 16'd1;
      4'd13: return {a, b};
      4'd14: return 16'(a);
      default: return 16'(b);
    endcase
  endfunction

  assign alu_out = alu_oe ? alu_ref(alu_a, alu_b, alu_cmd) : 16'h0000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [NREQ-1:0] v, int unsigned rr);
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = (int'(rr) + k) % int'(NREQ);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Transaction-level reference: one op in flight, age counts cycles since accept.
  bit              started = 0;
  bit              m_have  = 0;
  int              m_age   = 0;
  int unsigned     m_rr    = 0;
  int unsigned     m_id    = 0;
  logic [7:0]      m_a     = '0;
  logic [7:0]      m_b     = '0;
  logic [3:0]      m_cmd   = '0;
  logic [15:0]     m_data  = '0;
  bit              m_err   = 0;
  logic [NREQ-1:0] m_grant_vec = '0;

  always @(posedge clk) begin
    m_grant_vec <= '0;
    if (rst) begin
      started <= 1;
      m_have  <= 0;
      m_age   <= 0;
      m_rr    <= 0;
      m_id    <= 0;
      m_a     <= '0;
      m_b     <= '0;
      m_cmd   <= '0;
      m_data  <= '0;
      m_err   <= 0;
    end else if (started) begin
      if (!m_have) begin
        if (pick(req_valid, m_rr) >= 0) begin
          m_id    <= pick(req_valid, m_rr);
          m_a     <= req_a[pick(req_valid, m_rr)*8 +: 8];
          m_b     <= req_b[pick(req_valid, m_rr)*8 +: 8];
          m_cmd   <= req_cmd[pick(req_valid, m_rr)*4 +: 4];
          m_rr    <= (pick(req_valid, m_rr) + 1) % NREQ;
          m_have  <= 1;
          m_age   <= 1;
          m_grant_vec[pick(req_valid, m_rr)] <= 1'b1;
        end
      end else if (m_age == 1) begin
        m_err  <= (m_cmd == DIV) && (m_b == 0);
        m_data <= ((m_cmd == DIV) && (m_b == 0)) ? 16'h0000 : alu_ref(m_a, m_b, m_cmd);
        m_age  <= 2;
      end else if (rsp_ready) begin
        m_have <= 0;
      end
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    if (started) begin
      logic [NREQ-1:0] exp_ready;
      exp_ready = '0;
      if (!rst && !m_have && pick(req_valid, m_rr) >= 0)
        exp_ready[pick(req_valid, m_rr)] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_have));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_have && m_age >= 2));
      chk("alu_oe", 32'(alu_oe), 32'(m_have && m_age == 1 && !((m_cmd == DIV) && (m_b == 0))));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_cmd", 32'(alu_cmd), 32'(m_cmd));
      if (m_have && m_age >= 2) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, logic [7:0] a, logic [7:0] b, logic [3:0] c);
    req_a[i*8 +: 8]   = a;
    req_b[i*8 +: 8]   = b;
    req_cmd[i*4 +: 4] = c;
  endtask

  task automatic new_op(int i);
    logic [7:0] b;
    logic [3:0] c;
    b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    c = ($urandom_range(0, 3) == 0) ? DIV : 4'($urandom);
    set_op(i, 8'($urandom), b, c);
    req_valid[i] = 1'b1;
  endtask

  int g_id[$];
  int g_cyc[$];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cmd = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_alu_oe", 32'(alu_oe), 0);

    // Single ADD from requester 0.
    tick();
    set_op(0, 8'h12, 8'h34, ADD);
    req_valid = 4'b0001;
    @(negedge clk); chk("add_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    @(negedge clk); chk("add_oe", 32'(alu_oe), 1); chk("add_alu_a", 32'(alu_a), 32'h12);
    tick();
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid), 1);
    chk("add_rsp_data", 32'(rsp_data), 32'h0046);
    chk("add_rsp_id", 32'(rsp_id), 0);
    chk("add_rsp_err", 32'(rsp_err), 0);
    tick();

    // Divide by zero from requester 2 (pointer now at 1).
    set_op(2, 8'h40, 8'h00, DIV);
    req_valid = 4'b0100;
    @(negedge clk); chk("div_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    @(negedge clk); chk("div_oe", 32'(alu_oe), 0); chk("div_busy", 32'(busy), 1);
    tick();
    @(negedge clk);
    chk("div_rsp_err", 32'(rsp_err), 1);
    chk("div_rsp_data", 32'(rsp_data), 0);
    chk("div_rsp_id", 32'(rsp_id), 2);
    tick();

    // MUL from requester 1 stalled by rsp_ready; requester 3 waits.
    set_op(1, 8'hFF, 8'hFF, MUL);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(negedge clk); chk("mul_ready", 32'(req_ready), 32'h2);
    tick();
    set_op(3, 8'h01, 8'h02, ADD);
    req_valid = 4'b1000;
    tick();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("mul_stall_valid", 32'(rsp_valid), 1);
      chk("mul_stall_data", 32'(rsp_data), 32'hFE01);
      chk("mul_stall_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("mul_exit_ready", 32'(req_ready), 0);
    tick();
    @(negedge clk); chk("req3_after_drain", 32'(req_ready), 32'h8);
    tick(); req_valid = '0;
    tick(); tick();

    // Fairness with all requesters valid; pointer is at 0.
    for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom), ADD);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) begin g_id.push_back(i); g_cyc.push_back(c); end
      tick();
    end
    req_valid = '0;
    chk("fair_count", 32'(g_id.size()), 5);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      chk("fair_id", 32'(g_id[k]), 32'(k % 4));
      chk("fair_cycle", 32'(g_cyc[k]), 32'(3 * k));
    end

    // Move the pointer to 3, then requesters 3 and 0 compete.
    req_valid = 4'b0100;
    @(negedge clk); chk("ptr_setup", 32'(req_ready), 32'h4);
    tick(); req_valid = '0; tick(); tick();
    req_valid = 4'b1001;
    @(negedge clk); chk("wrap_first", 32'(req_ready), 32'h8);
    tick(); req_valid = 4'b0001; tick(); tick();
    @(negedge clk); chk("wrap_second", 32'(req_ready), 32'h1);
    tick(); req_valid = '0; tick(); tick();

    // Reset during EXEC with the pointer at 2.
    req_valid = 4'b0010;
    @(negedge clk); chk("rst_pre_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    tick(); req_valid = 4'b0110;
    @(negedge clk); chk("rst_ptr_zero", 32'(req_ready), 32'h2);
    tick(); req_valid = '0; tick(); tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if (m_grant_vec[i]) begin
          if ($urandom_range(0, 1) == 1) new_op(i);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_op(i);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
